stack_drain: RTL

Pop-side controller for the LIFO stack. Accepts a drain command, issues single-cycle pops against the stack's pop/empty/r_data interface, and presents the popped words, newest first, on a valid/ready output stream with a last marker. The stack's push side remains owned by upstream writers. A 2-entry output buffer gives one word per cycle throughput, and `st_pop` never depends combinationally on `m_ready`.

---
 rtl/stack_drain_pkg.sv | 17 +
 rtl/skid_buf2.sv | 60 ++++++
 rtl/stack_drain.sv | 126 ++++++++++++
 3 files changed

// File: rtl/stack_drain_pkg.sv
// Shared types and helpers for the stack drain controller.
package stack_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int unsigned STACK_W = 4;

  // Length/count fields hold 0..2**w, so they need one bit more than the address.
  function automatic int unsigned len_w(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry FIFO-ordered valid/ready buffer; load and unload may coincide at any occupancy.
module skid_buf2 #(
  parameter int unsigned P = 9
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [P-1:0] load_data,
  output logic         valid,
  output logic [P-1:0] data,
  input  logic         ready,
  output logic [1:0]   occ
);

  logic [P-1:0] head;
  logic [P-1:0] tail;
  logic [1:0]   count;
  logic         give;

  assign give  = ready && (count != 2'd0);
  assign valid = (count != 2'd0);
  assign data  = head;
  assign occ   = count;

  // Entry storage and occupancy; head always holds the oldest word.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (load) begin
            head  <= load_data;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (load && give) begin
            head <= load_data;
          end else if (load) begin
            tail  <= load_data;
            count <= 2'd2;
          end else if (give) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (give) begin
            head <= tail;
            if (load) tail <= load_data;
            else count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/stack_drain.sv
// Pop-side controller: drains the LIFO newest-first onto a valid/ready stream with a last marker.
module stack_drain
  import stack_drain_pkg::*;
#(
  parameter int unsigned B = 8,
  parameter int unsigned W = STACK_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  input  logic [W:0]   cmd_len,
  output logic         cmd_ready,
  input  logic         st_empty,
  input  logic [B-1:0] st_r_data,
  output logic         st_pop,
  output logic [B-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         done,
  output logic [W:0]   drained
);

  localparam int unsigned L = len_w(W);

  state_t         state;
  state_t         state_nx;
  logic           all_mode;
  logic           exhausted;
  logic [L-1:0]   remaining;
  logic [L-1:0]   delivered;
  logic           accept;
  logic           hs;
  logic           pop_last;
  logic [1:0]     occ;
  logic [B:0]     head;

  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign st_pop    = (state == DRAIN) && !st_empty && (occ <= 2'd1) && !exhausted
                     && (all_mode || (remaining != '0)) && !reset;
  assign pop_last  = !all_mode && (remaining == L'(1));
  assign hs        = m_valid && m_ready;
  assign m_data    = head[B:1];

  // In all mode the end of stream is only known once the stack reads empty, so last
  // is derived live from occupancy rather than stored with the entry.
  assign m_last = all_mode
                ? ((exhausted || ((state == DRAIN) && st_empty)) && (occ == 2'd1))
                : (head[0] && m_valid);

  skid_buf2 #(.P(B + 1)) u_buf (
    .clk       (clk),
    .clear     (reset || accept),
    .load      (st_pop),
    .load_data ({st_r_data, pop_last}),
    .valid     (m_valid),
    .data      (head),
    .ready     (m_ready),
    .occ       (occ)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and completion pulse.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = DRAIN;
      end
      DRAIN: begin
        if (all_mode) begin
          if (st_empty) begin
            // The final word can already be handshaking as the stack reads empty;
            // finish here instead of waiting in FLUSH for a word that is gone.
            if ((occ == 2'd0) || ((occ == 2'd1) && hs)) begin
              state_nx = IDLE;
              done     = 1'b1;
            end else begin
              state_nx = FLUSH;
            end
          end
        end else if (st_pop && pop_last) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (hs && m_last) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Command latch, length/exhaustion tracking and delivered count.
  always_ff @(posedge clk) begin
    if (reset) begin
      all_mode  <= 1'b0;
      exhausted <= 1'b0;
      remaining <= '0;
      delivered <= '0;
      drained   <= '0;
    end else begin
      if (accept) begin
        all_mode  <= (cmd_len == '0);
        remaining <= cmd_len;
        exhausted <= 1'b0;
        delivered <= '0;
      end else begin
        if (st_pop && !all_mode) remaining <= remaining - L'(1);
        if ((state == DRAIN) && all_mode && st_empty) exhausted <= 1'b1;
        if (hs) delivered <= delivered + L'(1);
      end
      if (done) drained <= delivered + {{(L-1){1'b0}}, hs};
    end
  end

endmodule
